riscv_run_monitor: RTL and testbench
====================================

// Module: riscv_run_monitor
// PURPOSE
// - Synthesisable run-control and completion monitor for one or more RISC-V unicycle harts.
// - Sequences the core reset for a fixed number of cycles, then runs the cores.
// - Latches each hart's finish_flag and counts cycles (and, optionally, retired instructions).
// - Ends each run with pass, timeout or abort; sits between the harness/top level and the cores.
// PARAMETERS
// - NUM_HARTS       1       number of monitored harts (>=1)
// - CNT_W           32      width of cycle/retire counters
// - RST_CYCLES      4       cycles core_rst is held after start (>=1)
// - TIMEOUT_CYCLES  100000  RUN cycles before timeout; 0 = timeout disabled
// PORTS
// - clock         in   1          system clock, rising edge
// - rst           in   1          asynchronous, active-low reset
// - start         in   1          pulse: begin a run (accepted in IDLE and DONE only)
// - abort         in   1          pulse: end the current RUN as fail
// - finish_flag   in   NUM_HARTS  per-hart finish indication from the cores
// - retire        in   NUM_HARTS  per-hart instruction-retired strobe
// - core_rst      out  1          active-high reset driven to the cores
// - run_active    out  1          1 while in RUN
// - done          out  1          1 while in DONE (run finished)
// - pass          out  1          run ended with every hart finished
// - timeout       out  1          run ended because the timeout expired
// - hart_done     out  NUM_HARTS  sticky per-hart finish mask
// - cycle_count   out  CNT_W      RUN cycles elapsed, saturating
// - retire_count  out  CNT_W      total retired instructions, saturating
// BEHAVIOUR
// - rst=0 forces, asynchronously:
//   - state=IDLE, core_rst=1
//   - run_active=0, done=0, pass=0, timeout=0
//   - hart_done=0, counts=0, edge registers=0
// - All outputs are registered.
// - FSM: IDLE -> RESET_HOLD -> RUN -> DONE; DONE -> RESET_HOLD on start.
// - IDLE:
//   - core_rst=1.
//   - start -> RESET_HOLD next cycle.
//   - Counts, hart_done, pass and timeout are cleared on that transition.
// - RESET_HOLD:
//   - core_rst=1 for exactly RST_CYCLES cycles, then RUN.
//   - core_rst=0 from the first RUN cycle.
//   - start and abort are ignored.
// - RUN:
//   - run_active=1; cycle_count +1 per cycle, saturating at 2^CNT_W-1.
//   - finish_flag rising edge (prev sample vs current; prev forced to 0 in RESET_HOLD) sets the hart_done bit.
//   - A flag already high on the first RUN cycle counts as an edge.
//   - hart_done reaching all-ones -> DONE with pass=1.
//   - Timeout: if TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 with hart_done not full -> DONE, timeout=1, pass=0.
//   - abort -> DONE with pass=0, timeout=0.
//   - Same-cycle priority: all-done beats timeout; timeout beats abort.
//   - start is ignored.
// - DONE:
//   - done=1, core_rst=1 (cores frozen).
//   - Counts, hart_done, pass and timeout are held.
//   - start clears status and re-enters RESET_HOLD.
// - Latency:
//   - finish_flag edge -> hart_done bit set: 1 cycle.
//   - Final hart edge -> done=1: 2 cycles.
// - rst asserted mid-run aborts immediately to the reset values; nothing is retained.
// CONFIGURATION
// - MON_PERF_EN defined:
//   - In RUN, retire_count adds popcount(retire) each cycle, saturating at 2^CNT_W-1.
//   - retire is ignored outside RUN.
// - MON_PERF_EN undefined:
//   - retire_count tied to 0; the retire input is unused and no adder is built.
// TESTING
// - NUM_HARTS=1, RST_CYCLES=4: start, finish_flag high on RUN cycle 10
//   -> core_rst=1 for 4 cycles; done=1, pass=1, cycle_count=11.
// - NUM_HARTS=2: hart0 finishes at cycle 5, hart1 at cycle 20
//   -> hart_done=01 then 11; pass only after hart1.
// - TIMEOUT_CYCLES=16, no finish_flag
//   -> done at RUN cycle 16, timeout=1, pass=0, cycle_count=16.
// - Last hart finishes on the timeout cycle
//   -> pass=1, timeout=0.
// - MON_PERF_EN, NUM_HARTS=2, both retire high for 8 RUN cycles
//   -> retire_count=16; without the macro -> 0.
// - rst=0 during RUN at cycle 7
//   -> all outputs reset within the same cycle; start again gives a fresh run from cycle_count=0.

Source files
------------

// File: rtl/riscv_run_monitor_if.sv
// Run-control bus between the harness (master) and riscv_run_monitor (slave).
// Carries the run commands, the per-hart core status and the monitor status back out.
interface riscv_run_monitor_if #(
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned CNT_W     = 32
) ();
    logic                 start;
    logic                 abort;
    logic [NUM_HARTS-1:0] finish_flag;
    logic [NUM_HARTS-1:0] retire;
    logic                 core_rst;
    logic                 run_active;
    logic                 done;
    logic                 pass;
    logic                 timeout;
    logic [NUM_HARTS-1:0] hart_done;
    logic [CNT_W-1:0]     cycle_count;
    logic [CNT_W-1:0]     retire_count;

    modport master (
        output start, abort, finish_flag, retire,
        input  core_rst, run_active, done, pass, timeout,
        input  hart_done, cycle_count, retire_count
    );

    modport slave (
        input  start, abort, finish_flag, retire,
        output core_rst, run_active, done, pass, timeout,
        output hart_done, cycle_count, retire_count
    );
endinterface

// File: rtl/riscv_run_monitor.sv
// Run-control and completion monitor for RISC-V harts: core reset sequencing, finish tracking, cycle counting.
// Optional MON_PERF_EN macro adds a saturating retired-instruction counter.
module riscv_run_monitor #(
    parameter int unsigned NUM_HARTS      = 1,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic               clock,
    input  logic               rst,
    riscv_run_monitor_if.slave bus
);
    localparam int unsigned          HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]     TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit                   TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [NUM_HARTS-1:0] ALL_DONE  = '1;

    typedef enum logic [1:0] {
        IDLE,
        RESET_HOLD,
        RUN,
        DONE
    } state_t;

    state_t               state;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [NUM_HARTS-1:0] flag_prev;
    logic [NUM_HARTS-1:0] hart_done_q;
    logic [CNT_W-1:0]     cycle_q;
    logic                 core_rst_q;
    logic                 run_active_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 timeout_q;

    logic [NUM_HARTS-1:0] rise_c;
    logic [CNT_W-1:0]     cycle_inc_c;
    logic                 all_done_c;
    logic                 timeout_hit_c;

    // Termination decisions look at the registered mask, giving the two-cycle edge-to-done latency.
    always_comb begin
        rise_c        = bus.finish_flag & ~flag_prev;
        cycle_inc_c   = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);
        all_done_c    = (hart_done_q == ALL_DONE);
        timeout_hit_c = TO_EN && (cycle_q == TO_LAST);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            flag_prev    <= '0;
            hart_done_q  <= '0;
            cycle_q      <= '0;
            core_rst_q   <= 1'b1;
            run_active_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    core_rst_q <= 1'b1;
                    if (bus.start) begin
                        state       <= RESET_HOLD;
                        hold_cnt    <= '0;
                        hart_done_q <= '0;
                        cycle_q     <= '0;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        done_q      <= 1'b0;
                    end
                end
                RESET_HOLD: begin
                    // Forcing the previous sample low makes an already-high flag count as an edge.
                    flag_prev <= '0;
                    if (hold_cnt == HOLD_LAST) begin
                        state        <= RUN;
                        core_rst_q   <= 1'b0;
                        run_active_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    cycle_q     <= cycle_inc_c;
                    flag_prev   <= bus.finish_flag;
                    hart_done_q <= hart_done_q | rise_c;
                    if (all_done_c || timeout_hit_c || bus.abort) begin
                        state        <= DONE;
                        run_active_q <= 1'b0;
                        done_q       <= 1'b1;
                        core_rst_q   <= 1'b1;
                        pass_q       <= all_done_c;
                        timeout_q    <= !all_done_c && timeout_hit_c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MON_PERF_EN
    localparam int unsigned PC_W  = $clog2(NUM_HARTS + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [PC_W-1:0]  pop_c;
    logic [SUM_W-1:0] sum_c;
    logic [CNT_W-1:0] retire_next_c;
    logic [CNT_W-1:0] retire_q;

    // Per-cycle popcount of retire strobes, accumulated with saturation.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < int'(NUM_HARTS); i++) begin
            pop_c = pop_c + PC_W'(bus.retire[i]);
        end
        sum_c         = {1'b0, retire_q} + SUM_W'(pop_c);
        retire_next_c = sum_c[CNT_W] ? CNT_MAX : sum_c[CNT_W-1:0];
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
        end else if ((state == IDLE || state == DONE) && bus.start) begin
            retire_q <= '0;
        end else if (state == RUN) begin
            retire_q <= retire_next_c;
        end
    end

    assign bus.retire_count = retire_q;
`else
    assign bus.retire_count = '0;
`endif

    assign bus.core_rst    = core_rst_q;
    assign bus.run_active  = run_active_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.timeout     = timeout_q;
    assign bus.hart_done   = hart_done_q;
    assign bus.cycle_count = cycle_q;
endmodule

// File: tb/tb_riscv_run_monitor.sv
// Directed bench for riscv_run_monitor: three configurations share clock and reset,
// run outcomes are queued when a run is started and compared when done rises.
module tb_riscv_run_monitor;
    logic clock = 1'b0;
    logic rst;

    always #5 clock = ~clock;

`ifdef MON_PERF_EN
    localparam logic [31:0] EXP_RET = 32'd16;
`else
    localparam logic [31:0] EXP_RET = 32'd0;
`endif

    riscv_run_monitor_if #(.NUM_HARTS(1), .CNT_W(32)) ifa ();
    riscv_run_monitor_if #(.NUM_HARTS(2), .CNT_W(32)) ifb ();
    riscv_run_monitor_if #(.NUM_HARTS(2), .CNT_W(32)) ifc ();

    riscv_run_monitor #(.NUM_HARTS(1), .CNT_W(32), .RST_CYCLES(4), .TIMEOUT_CYCLES(100000))
        dut_a (.clock(clock), .rst(rst), .bus(ifa.slave));
    riscv_run_monitor #(.NUM_HARTS(2), .CNT_W(32), .RST_CYCLES(4), .TIMEOUT_CYCLES(100000))
        dut_b (.clock(clock), .rst(rst), .bus(ifb.slave));
    riscv_run_monitor #(.NUM_HARTS(2), .CNT_W(32), .RST_CYCLES(4), .TIMEOUT_CYCLES(16))
        dut_c (.clock(clock), .rst(rst), .bus(ifc.slave));

    typedef struct packed {
        logic        core_rst;
        logic        run_active;
        logic        done;
        logic        pass;
        logic        timeout;
        logic [1:0]  hart_done;
        logic [31:0] cycle_count;
        logic [31:0] retire_count;
    } obs_t;

    typedef struct packed {
        logic        pass;
        logic        timeout;
        logic [1:0]  hart_done;
        logic [31:0] cycles;
        logic [31:0] retires;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic get_obs(input int k, output obs_t o);
        case (k)
            0: o = '{ifa.core_rst, ifa.run_active, ifa.done, ifa.pass, ifa.timeout,
                     {1'b0, ifa.hart_done}, ifa.cycle_count, ifa.retire_count};
            1: o = '{ifb.core_rst, ifb.run_active, ifb.done, ifb.pass, ifb.timeout,
                     ifb.hart_done, ifb.cycle_count, ifb.retire_count};
            default: o = '{ifc.core_rst, ifc.run_active, ifc.done, ifc.pass, ifc.timeout,
                     ifc.hart_done, ifc.cycle_count, ifc.retire_count};
        endcase
    endtask

    task automatic set_ctl(input int k, input logic s, input logic a);
        case (k)
            0:       begin ifa.start = s; ifa.abort = a; end
            1:       begin ifb.start = s; ifb.abort = a; end
            default: begin ifc.start = s; ifc.abort = a; end
        endcase
    endtask

    task automatic set_flag(input int k, input logic [1:0] f);
        case (k)
            0:       ifa.finish_flag = f[0];
            1:       ifb.finish_flag = f;
            default: ifc.finish_flag = f;
        endcase
    endtask

    task automatic expect_run(input logic p, input logic t, input logic [1:0] hd,
                              input logic [31:0] cyc, input logic [31:0] ret);
        sb.push_back('{p, t, hd, cyc, ret});
    endtask

    task automatic start_pulse(input int k);
        set_ctl(k, 1'b1, 1'b0);
        tick();
        set_ctl(k, 1'b0, 1'b0);
    endtask

    // Core reset must stay high for exactly four cycles; optional noise on start/abort is ignored.
    task automatic hold_phase(input int k, input logic noise);
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            set_ctl(k, noise && i < 3, noise && i < 3);
            get_obs(k, o);
            check($sformatf("hold%0d.c%0d.core_rst", k, i), 64'(o.core_rst), 64'd1);
            check($sformatf("hold%0d.c%0d.run_active", k, i), 64'(o.run_active), 64'd0);
            tick();
        end
        get_obs(k, o);
        check($sformatf("run%0d.core_rst", k), 64'(o.core_rst), 64'd0);
        check($sformatf("run%0d.run_active", k), 64'(o.run_active), 64'd1);
        check($sformatf("run%0d.cycle0", k), 64'(o.cycle_count), 64'd0);
    endtask

    task automatic finish_run(input int k, input string tag);
        obs_t o;
        exp_t e;
        int   n = 0;
        get_obs(k, o);
        while (!o.done && n < 300) begin
            tick();
            n++;
            get_obs(k, o);
        end
        check({tag, ".done"}, 64'(o.done), 64'd1);
        check({tag, ".sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".pass"}, 64'(o.pass), 64'(e.pass));
            check({tag, ".timeout"}, 64'(o.timeout), 64'(e.timeout));
            check({tag, ".hart_done"}, 64'(o.hart_done), 64'(e.hart_done));
            check({tag, ".cycle_count"}, 64'(o.cycle_count), 64'(e.cycles));
            check({tag, ".retire_count"}, 64'(o.retire_count), 64'(e.retires));
            check({tag, ".core_rst"}, 64'(o.core_rst), 64'd1);
            check({tag, ".run_active"}, 64'(o.run_active), 64'd0);
        end
    endtask

    initial begin
        obs_t o;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_ctl(k, 1'b0, 1'b0);
            set_flag(k, 2'b00);
        end
        ifa.retire = '0;
        ifb.retire = '0;
        ifc.retire = '0;
        ticks(2);

        // Reset values on every instance
        for (int k = 0; k < 3; k++) begin
            get_obs(k, o);
            check($sformatf("reset%0d.core_rst", k), 64'(o.core_rst), 64'd1);
            check($sformatf("reset%0d.flags", k),
                  64'({o.run_active, o.done, o.pass, o.timeout}), 64'd0);
            check($sformatf("reset%0d.hart_done", k), 64'(o.hart_done), 64'd0);
            check($sformatf("reset%0d.counts", k), {o.cycle_count, o.retire_count}, 64'd0);
        end
        rst = 1'b1;
        tick();

        // One hart, flag rises on RUN cycle 10
        expect_run(1'b1, 1'b0, 2'b01, 32'd11, 32'd0);
        start_pulse(0);
        hold_phase(0, 1'b0);
        ticks(9);
        get_obs(0, o);
        check("single.cycle10", 64'(o.cycle_count), 64'd9);
        set_flag(0, 2'b01);
        tick();
        get_obs(0, o);
        check("single.hd_latency", 64'(o.hart_done), 64'd1);
        check("single.not_done_yet", 64'(o.done), 64'd0);
        tick();
        finish_run(0, "single");
        set_flag(0, 2'b00);

        // Two harts finishing at cycles 5 and 20, both retiring for the first 8 RUN cycles
        expect_run(1'b1, 1'b0, 2'b11, 32'd21, EXP_RET);
        start_pulse(1);
        ifb.retire = 2'b11;
        hold_phase(1, 1'b0);
        for (int c = 1; c <= 21; c++) begin
            ifb.retire = (c <= 8) ? 2'b11 : 2'b00;
            if (c == 5)  set_flag(1, 2'b01);
            if (c == 20) set_flag(1, 2'b11);
            get_obs(1, o);
            if (c == 6) begin
                check("dual.hd_first", 64'(o.hart_done), 64'd1);
                check("dual.not_done_first", 64'(o.done), 64'd0);
            end
            if (c == 21) begin
                check("dual.hd_both", 64'(o.hart_done), 64'd3);
                check("dual.no_early_pass", 64'(o.pass), 64'd0);
            end
            tick();
        end
        finish_run(1, "dual");
        ifb.retire = 2'b11;
        ticks(2);
        get_obs(1, o);
        check("dual.retire_held_in_done", 64'(o.retire_count), 64'(EXP_RET));
        ifb.retire = 2'b00;
        set_flag(1, 2'b00);

        // Timeout of 16 with no finish flags
        expect_run(1'b0, 1'b1, 2'b00, 32'd16, 32'd0);
        start_pulse(2);
        hold_phase(2, 1'b0);
        ticks(15);
        get_obs(2, o);
        check("timeout.not_done_c16", 64'(o.done), 64'd0);
        tick();
        finish_run(2, "timeout");

        // Restart from DONE; hart0 flag already high counts as an edge, hart1 lands on the timeout cycle
        expect_run(1'b1, 1'b0, 2'b11, 32'd16, 32'd0);
        set_flag(2, 2'b01);
        start_pulse(2);
        get_obs(2, o);
        check("restart.cleared", 64'({o.done, o.pass, o.timeout, o.hart_done}), 64'd0);
        check("restart.count_cleared", 64'(o.cycle_count), 64'd0);
        hold_phase(2, 1'b0);
        tick();
        get_obs(2, o);
        check("restart.preheld_edge", 64'(o.hart_done), 64'd1);
        ticks(13);
        set_flag(2, 2'b11);
        tick();
        get_obs(2, o);
        check("restart.full_on_timeout_cycle", {32'(o.hart_done), o.cycle_count}, {32'd3, 32'd15});
        tick();
        finish_run(2, "alldone_vs_timeout");
        set_flag(2, 2'b00);

        // Abort and start ignored in RESET_HOLD, start ignored in RUN, abort ends the run
        expect_run(1'b0, 1'b0, 2'b00, 32'd3, 32'd0);
        start_pulse(2);
        hold_phase(2, 1'b1);
        tick();
        set_ctl(2, 1'b1, 1'b0);
        tick();
        set_ctl(2, 1'b0, 1'b0);
        get_obs(2, o);
        check("abort.start_ignored", {32'(o.run_active), o.cycle_count}, {32'd1, 32'd2});
        set_ctl(2, 1'b0, 1'b1);
        tick();
        set_ctl(2, 1'b0, 1'b0);
        finish_run(2, "abort");

        // Abort on the timeout cycle loses to timeout
        expect_run(1'b0, 1'b1, 2'b00, 32'd16, 32'd0);
        start_pulse(2);
        hold_phase(2, 1'b0);
        ticks(15);
        set_ctl(2, 1'b0, 1'b1);
        tick();
        set_ctl(2, 1'b0, 1'b0);
        finish_run(2, "timeout_vs_abort");

        // Asynchronous reset during RUN cycle 7, then a fresh run
        start_pulse(0);
        hold_phase(0, 1'b0);
        ticks(6);
        get_obs(0, o);
        check("midrst.cycle7", 64'(o.cycle_count), 64'd6);
        rst = 1'b0;
        #1;
        get_obs(0, o);
        check("midrst.core_rst", 64'(o.core_rst), 64'd1);
        check("midrst.flags", 64'({o.run_active, o.done, o.pass, o.timeout}), 64'd0);
        check("midrst.count", 64'(o.cycle_count), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        expect_run(1'b1, 1'b0, 2'b01, 32'd4, 32'd0);
        start_pulse(0);
        hold_phase(0, 1'b0);
        ticks(2);
        get_obs(0, o);
        check("fresh.cycle3", 64'(o.cycle_count), 64'd2);
        set_flag(0, 2'b01);
        ticks(2);
        finish_run(0, "fresh");
        set_flag(0, 2'b00);

        check("sb.drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
